card_deck_dealer: RTL and testbench



---
 rtl/card_deck_dealer.sv | 132 +++++++++++++
 tb/tb_card_deck_dealer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_deck_dealer.sv
// Deals card values 1..13 from a finite deck, without replacement, one card per
// rising edge of pip. The value is chosen by a free-running LFSR plus a linear probe.
module card_deck_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          COPIES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pip,
    input  logic       new_deck,
    output logic [3:0] number,
    output logic       valid,
    output logic       busy,
    output logic       empty,
    output logic [5:0] cards_left
);

    typedef enum logic [1:0] {IDLE, PICK, PROBE, EMIT} state_t;

    localparam logic [5:0] FULL_DECK = 6'(13 * COPIES);
    localparam logic [2:0] FULL_CNT  = 3'(COPIES);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        pip_q, pip_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  number_q, number_d;
    logic        valid_q, valid_d;
    logic [5:0]  left_q, left_d;
    logic [2:0]  count_q [13];
    logic [2:0]  count_d [13];

    logic        req;
    logic [3:0]  pick_val;
    logic [2:0]  cand_cnt;

    // Entropy comes from the human timing of pip, so the LFSR never pauses.
    always_comb begin
        if (lfsr_q == 16'd0) begin
            lfsr_d = LFSR_SEED;
        end else begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign pip_d    = pip;
    assign req      = pip & ~pip_q;
    assign pick_val = (lfsr_q[3:0] >= 4'd13) ? (lfsr_q[3:0] - 4'd12) : (lfsr_q[3:0] + 4'd1);

    // Mux the candidate's counter out explicitly so an out-of-range cand never indexes.
    always_comb begin
        cand_cnt = 3'd0;
        for (int i = 0; i < 13; i++) begin
            if (cand_q == 4'(i + 1)) cand_cnt = count_q[i];
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        number_d = 4'd0;
        valid_d  = 1'b0;
        left_d   = left_q;
        count_d  = count_q;

        if (new_deck) begin
            state_d = IDLE;
            left_d  = FULL_DECK;
            for (int i = 0; i < 13; i++) count_d[i] = FULL_CNT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && (left_q != 6'd0)) state_d = PICK;
                end
                PICK: begin
                    cand_d  = pick_val;
                    state_d = PROBE;
                end
                PROBE: begin
                    if (cand_cnt != 3'd0) begin
                        state_d = EMIT;
                    end else begin
                        cand_d = (cand_q == 4'd13) ? 4'd1 : (cand_q + 4'd1);
                    end
                end
                EMIT: begin
                    number_d = cand_q;
                    valid_d  = 1'b1;
                    if (left_q != 6'd0) left_d = left_q - 6'd1;
                    for (int i = 0; i < 13; i++) begin
                        if ((cand_q == 4'(i + 1)) && (count_q[i] != 3'd0)) begin
                            count_d[i] = count_q[i] - 3'd1;
                        end
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the per-value counters are plain flops rather than a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            pip_q    <= 1'b0;
            cand_q   <= 4'd0;
            number_q <= 4'd0;
            valid_q  <= 1'b0;
            left_q   <= FULL_DECK;
            for (int i = 0; i < 13; i++) count_q[i] <= FULL_CNT;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            pip_q    <= pip_d;
            cand_q   <= cand_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            left_q   <= left_d;
            count_q  <= count_d;
        end
    end

    assign number     = number_q;
    assign valid      = valid_q;
    assign busy       = (state_q != IDLE);
    assign empty      = (left_q == 6'd0);
    assign cards_left = left_q;

endmodule

// File: tb/tb_card_deck_dealer.sv
// Scoreboard bench for card_deck_dealer: a reference LFSR and deck model predict
// each dealt value and the cycle it appears, and the monitor pops and compares.
module tb_card_deck_dealer;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          COPIES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pip = 1'b0;
    logic       new_deck = 1'b0;
    logic [3:0] number;
    logic       valid;
    logic       busy;
    logic       empty;
    logic [5:0] cards_left;

    card_deck_dealer #(.LFSR_SEED(SEED), .COPIES(COPIES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pip        (pip),
        .new_deck   (new_deck),
        .number     (number),
        .valid      (valid),
        .busy       (busy),
        .empty      (empty),
        .cards_left (cards_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int          tb_cyc = 0;
    logic [15:0] m_lfsr;
    int          m_cnt[16];
    int          m_left;
    int          hist[16];

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, zero reloads the seed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)               m_lfsr <= SEED;
        else if (m_lfsr == 16'd0) m_lfsr <= SEED;
        else                      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic model_refill();
        for (int v = 0; v < 16; v++) m_cnt[v] = (v >= 1 && v <= 13) ? COPIES : 0;
        m_left = 13 * COPIES;
        sb.delete();
    endtask

    // Raises pip (request cycle T) and predicts the card from the LFSR value seen in PICK.
    task automatic start_deal();
        logic [3:0] c;
        int         k;
        exp_t       e;
        @(negedge clk);
        pip = 1'b1;
        @(posedge clk);
        #1;
        if (m_left > 0) begin
            c = (m_lfsr[3:0] >= 4'd13) ? (m_lfsr[3:0] - 4'd12) : (m_lfsr[3:0] + 4'd1);
            k = 0;
            while (m_cnt[c] == 0) begin
                c = (c == 4'd13) ? 4'd1 : (c + 4'd1);
                k++;
            end
            e.num = c;
            e.cyc = tb_cyc + 3 + k;
            sb.push_back(e);
            m_cnt[c]--;
            m_left--;
        end
    endtask

    task automatic watch(input int ncyc);
        exp_t e;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                n_valid++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: got number=%0d at cycle %0d, required no emit", number, tb_cyc);
                end else begin
                    e = sb.pop_front();
                    if (number !== e.num || tb_cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL emit: got number=%0d at cycle %0d, required number=%0d at cycle %0d",
                                 number, tb_cyc, e.num, e.cyc);
                    end
                end
                hist[number]++;
            end else begin
                n_vec++;
                if (number !== 4'd0) begin
                    n_err++;
                    $display("FAIL idle_number: got number=%0d with valid=%b at cycle %0d, required 0", number, valid, tb_cyc);
                end
            end
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_emit: %0d expected card(s) never appeared, required 0 pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_left(input string name, input logic [5:0] exp_left, input logic exp_empty);
        n_vec++;
        if (cards_left !== exp_left || empty !== exp_empty) begin
            n_err++;
            $display("FAIL %s: got cards_left=%0d empty=%b, required cards_left=%0d empty=%b",
                     name, cards_left, empty, exp_left, exp_empty);
        end
    endtask

    task automatic check_nvalid(input string name, input int exp_n);
        n_vec++;
        if (n_valid != exp_n) begin
            n_err++;
            $display("FAIL %s: got %0d valid pulses, required %0d", name, n_valid, exp_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pip = 1'b0;
        new_deck = 1'b0;
        model_refill();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({number, valid, busy, empty, cards_left} !== {4'd0, 1'b0, 1'b0, 1'b0, 6'd52}) begin
            n_err++;
            $display("FAIL reset_hold: got number=%0d valid=%b busy=%b empty=%b cards_left=%0d, required 0 0 0 0 52",
                     number, valid, busy, empty, cards_left);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({number, valid, busy, empty, cards_left} !== {4'd0, 1'b0, 1'b0, 1'b0, 6'd52}) begin
            n_err++;
            $display("FAIL reset_release: got number=%0d valid=%b busy=%b empty=%b cards_left=%0d, required 0 0 0 0 52",
                     number, valid, busy, empty, cards_left);
        end
    endtask

    task automatic test_single_held();
        for (int v = 0; v < 16; v++) hist[v] = 0;
        n_valid = 0;
        start_deal();
        watch(100);
        @(negedge clk);
        pip = 1'b0;
        check_nvalid("held_pip_pulses", 1);
        check_left("held_pip_left", 6'd51, 1'b0);
    endtask

    task automatic test_full_deck();
        for (int d = 0; d < 51; d++) begin
            start_deal();
            watch(17);
            @(negedge clk);
            pip = 1'b0;
        end
        for (int v = 1; v <= 13; v++) begin
            n_vec++;
            if (hist[v] != COPIES) begin
                n_err++;
                $display("FAIL histogram: value %0d dealt %0d times, required %0d", v, hist[v], COPIES);
            end
        end
        check_left("drained", 6'd0, 1'b1);
        n_valid = 0;
        start_deal();
        watch(20);
        @(negedge clk);
        pip = 1'b0;
        check_nvalid("pip_on_empty", 0);
        check_left("pip_on_empty_left", 6'd0, 1'b1);
    endtask

    task automatic test_new_deck();
        @(negedge clk);
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
        model_refill();
        check_left("refill", 6'd52, 1'b0);
        n_valid = 0;
        start_deal();
        watch(17);
        @(negedge clk);
        pip = 1'b0;
        check_nvalid("deal_after_refill", 1);
        check_left("deal_after_refill_left", 6'd51, 1'b0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
        model_refill();
        start_deal();
        @(negedge clk);
        pip = 1'b0;
        @(negedge clk);
        new_deck = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: got busy=%b valid=%b, required 0 0", busy, valid);
        end
        model_refill();
        @(negedge clk);
        new_deck = 1'b0;
        n_valid = 0;
        watch(20);
        check_nvalid("abort_no_emit", 0);
        check_left("abort_left", 6'd52, 1'b0);
    endtask

    task automatic test_back_to_back();
        n_valid = 0;
        start_deal();
        @(negedge clk);
        pip = 1'b0;
        @(negedge clk);
        pip = 1'b1;
        watch(17);
        @(negedge clk);
        pip = 1'b0;
        check_nvalid("back_to_back_pulses", 1);
        check_left("back_to_back_left", 6'd51, 1'b0);
    endtask

    task automatic test_reset_mid_draw();
        start_deal();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({number, valid, busy, empty, cards_left} !== {4'd0, 1'b0, 1'b0, 1'b0, 6'd52}) begin
            n_err++;
            $display("FAIL reset_mid_draw: got number=%0d valid=%b busy=%b empty=%b cards_left=%0d, required 0 0 0 0 52",
                     number, valid, busy, empty, cards_left);
        end
        model_refill();
        @(negedge clk);
        pip = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        watch(20);
        check_nvalid("reset_mid_draw_no_emit", 0);
        check_left("reset_mid_draw_left", 6'd52, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_held();
        test_full_deck();
        test_new_deck();
        test_abort();
        test_back_to_back();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
